// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak absorb path: modes, rates, padding bytes.
// Optional protocol checking in keccak_absorb_buffer is enabled by ABSORB_PROTO_CHECK_EN.
package keccak_pkg;

   localparam int DWIDTH         = 256;
   localparam int KEEP_WIDTH     = 32;
   localparam int RATE_MAX_BITS  = 1344;
   localparam int RATE_MAX_BYTES = 168;
   localparam int CARRY_WIDTH    = 192;

   localparam logic [7:0] RATE_SHA3_256 = 8'd136;
   localparam logic [7:0] RATE_SHA3_512 = 8'd72;
   localparam logic [7:0] RATE_SHAKE128 = 8'd168;
   localparam logic [7:0] RATE_SHAKE256 = 8'd136;

   localparam logic [7:0] SHA3_SUFFIX_BYTE  = 8'h06;
   localparam logic [7:0] SHAKE_SUFFIX_BYTE = 8'h1F;
   localparam logic [7:0] PAD_FINAL_BYTE    = 8'h80;

   typedef enum logic [1:0] {
      SHA3_256 = 2'd0,
      SHA3_512 = 2'd1,
      SHAKE128 = 2'd2,
      SHAKE256 = 2'd3
   } keccak_mode;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ABSORB = 2'd1,
      PAD    = 2'd2,
      EMIT   = 2'd3
   } absorb_state_e;

   function automatic logic [7:0] rate_of(input keccak_mode m);
      case (m)
         SHA3_256: return RATE_SHA3_256;
         SHA3_512: return RATE_SHA3_512;
         SHAKE128: return RATE_SHAKE128;
         SHAKE256: return RATE_SHAKE256;
         default:  return RATE_SHA3_256;
      endcase
   endfunction

   function automatic logic [7:0] suffix_of(input keccak_mode m);
      case (m)
         SHAKE128, SHAKE256: return SHAKE_SUFFIX_BYTE;
         default:            return SHA3_SUFFIX_BYTE;
      endcase
   endfunction

   function automatic logic [5:0] keep_count(input logic [KEEP_WIDTH-1:0] k);
      logic [5:0] cnt;
      cnt = 6'd0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         cnt = cnt + 6'(k[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/keccak_pad_gen.sv
// Combinational pad10*1 generator: XORs the domain suffix at byte 'fill' and 0x80 at byte rate-1.
module keccak_pad_gen
   import keccak_pkg::*;
(
   input  logic [RATE_MAX_BITS-1:0] block_i,
   input  logic [7:0]               fill_i,
   input  logic [7:0]               rate_i,
   input  keccak_mode               mode_i,
   output logic [RATE_MAX_BITS-1:0] block_o
);

   logic [RATE_MAX_BITS-1:0] suffix_vec_s;
   logic [RATE_MAX_BITS-1:0] final_vec_s;

   // Both XORs land on the same byte when fill = rate-1, giving the combined pad byte.
   assign suffix_vec_s = RATE_MAX_BITS'(suffix_of(mode_i)) << {fill_i, 3'b000};
   assign final_vec_s  = RATE_MAX_BITS'(PAD_FINAL_BYTE) << {rate_i - 8'd1, 3'b000};
   assign block_o      = block_i ^ suffix_vec_s ^ final_vec_s;

endmodule

// File: rtl/keccak_absorb_buffer.sv
// Packs a byte-keyed 256-bit stream into padded rate blocks for the Keccak permutation.
// Define ABSORB_PROTO_CHECK_EN to add the sticky proto_err_o input-protocol flag.
module keccak_absorb_buffer
   import keccak_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   input  logic [1:0]               mode_i,
   input  logic [DWIDTH-1:0]        s_tdata,
   input  logic [KEEP_WIDTH-1:0]    s_tkeep,
   input  logic                     s_tlast,
   input  logic                     s_tvalid,
   output logic                     s_tready,
   output logic [RATE_MAX_BITS-1:0] m_block_o,
   output logic [7:0]               m_rate_bytes_o,
   output logic                     m_last_o,
   output logic                     m_valid_o,
   input  logic                     m_ready_i,
   output logic                     busy_o
`ifdef ABSORB_PROTO_CHECK_EN
   ,
   output logic                     proto_err_o
`endif
);

   localparam int WIDE_BITS = RATE_MAX_BITS + DWIDTH;

   absorb_state_e            state_r;
   keccak_mode               mode_r;
   logic [7:0]               rate_r;
   logic [RATE_MAX_BITS-1:0] block_r;
   logic [7:0]               fill_r;
   logic [CARRY_WIDTH-1:0]   carry_r;
   logic [7:0]               carry_cnt_r;
   logic                     last_seen_r;
   logic                     tready_r;
   logic                     valid_r;
   logic                     last_r;
   logic                     busy_r;

   logic [DWIDTH-1:0]        data_mask_s;
   logic [5:0]               n_s;
   logic [7:0]               sum_s;
   logic [WIDE_BITS-1:0]     wide_s;
   logic [RATE_MAX_BITS-1:0] rate_mask_s;
   logic [RATE_MAX_BITS-1:0] absorb_block_s;
   logic [CARRY_WIDTH-1:0]   carry_s;
   logic [RATE_MAX_BITS-1:0] pad_block_s;

   // Zero disabled bytes so shifted data can simply be OR-ed into the block.
   always_comb begin
      data_mask_s = '0;
      for (int k = 0; k < KEEP_WIDTH; k++) begin
         if (s_tkeep[k]) begin
            data_mask_s[8*k +: 8] = s_tdata[8*k +: 8];
         end else begin
            data_mask_s[8*k +: 8] = 8'h00;
         end
      end
   end

   // Beat placed at byte offset fill: bytes below the rate join the block, bytes above become carry.
   assign n_s            = keep_count(s_tkeep);
   assign sum_s          = fill_r + {2'b00, n_s};
   assign wide_s         = WIDE_BITS'(data_mask_s) << {fill_r, 3'b000};
   assign rate_mask_s    = ~({RATE_MAX_BITS{1'b1}} << {rate_r, 3'b000});
   assign absorb_block_s = block_r | (wide_s[RATE_MAX_BITS-1:0] & rate_mask_s);
   assign carry_s        = CARRY_WIDTH'(wide_s >> {rate_r, 3'b000});

   keccak_pad_gen u_pad_gen (
      .block_i (block_r),
      .fill_i  (fill_r),
      .rate_i  (rate_r),
      .mode_i  (mode_r),
      .block_o (pad_block_s)
   );

   // Control FSM with registered handshake/status outputs and the block datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         mode_r      <= SHA3_256;
         rate_r      <= 8'd0;
         block_r     <= '0;
         fill_r      <= 8'd0;
         carry_r     <= '0;
         carry_cnt_r <= 8'd0;
         last_seen_r <= 1'b0;
         tready_r    <= 1'b0;
         valid_r     <= 1'b0;
         last_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_i) begin
                  mode_r      <= keccak_mode'(mode_i);
                  rate_r      <= rate_of(keccak_mode'(mode_i));
                  block_r     <= '0;
                  fill_r      <= 8'd0;
                  carry_r     <= '0;
                  carry_cnt_r <= 8'd0;
                  last_seen_r <= 1'b0;
                  tready_r    <= 1'b1;
                  busy_r      <= 1'b1;
                  state_r     <= ABSORB;
               end
            end
            ABSORB: begin
               if (s_tvalid) begin
                  block_r <= absorb_block_s;
                  if (sum_s >= rate_r) begin
                     carry_r     <= carry_s;
                     carry_cnt_r <= sum_s - rate_r;
                     last_seen_r <= s_tlast;
                     tready_r    <= 1'b0;
                     valid_r     <= 1'b1;
                     last_r      <= 1'b0;
                     state_r     <= EMIT;
                  end else begin
                     fill_r <= sum_s;
                     if (s_tlast) begin
                        tready_r <= 1'b0;
                        state_r  <= PAD;
                     end
                  end
               end
            end
            PAD: begin
               block_r <= pad_block_s;
               valid_r <= 1'b1;
               last_r  <= 1'b1;
               state_r <= EMIT;
            end
            EMIT: begin
               if (m_ready_i) begin
                  valid_r <= 1'b0;
                  if (last_r) begin
                     last_r  <= 1'b0;
                     busy_r  <= 1'b0;
                     state_r <= IDLE;
                  end else begin
                     block_r     <= RATE_MAX_BITS'(carry_r);
                     fill_r      <= carry_cnt_r;
                     carry_r     <= '0;
                     carry_cnt_r <= 8'd0;
                     if (last_seen_r) begin
                        state_r <= PAD;
                     end else begin
                        tready_r <= 1'b1;
                        state_r  <= ABSORB;
                     end
                  end
               end
            end
            default: begin
               state_r  <= IDLE;
               tready_r <= 1'b0;
               valid_r  <= 1'b0;
               busy_r   <= 1'b0;
            end
         endcase
      end
   end

   assign s_tready       = tready_r;
   assign m_block_o      = block_r;
   assign m_rate_bytes_o = rate_r;
   assign m_last_o       = last_r;
   assign m_valid_o      = valid_r;
   assign busy_o         = busy_r;

`ifdef ABSORB_PROTO_CHECK_EN
   logic proto_err_r;
   logic keep_contig_s;

   assign keep_contig_s = ((s_tkeep & (s_tkeep + 32'd1)) == 32'd0);

   // Sticky flag for gapped byte enables or a short non-final beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         proto_err_r <= 1'b0;
      end else if (state_r == IDLE && start_i) begin
         proto_err_r <= 1'b0;
      end else if (state_r == ABSORB && s_tvalid &&
                   (!keep_contig_s || (!s_tlast && s_tkeep != 32'hFFFF_FFFF))) begin
         proto_err_r <= 1'b1;
      end
   end

   assign proto_err_o = proto_err_r;
`endif

endmodule

// File: tb/tb_keccak_absorb_buffer.sv
// Scoreboard bench: a byte-level pad10*1 model queues expected blocks, a monitor checks each handshake.
module tb_keccak_absorb_buffer;
   import keccak_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_i;
   logic [1:0]    mode_i;
   logic [255:0]  s_tdata;
   logic [31:0]   s_tkeep;
   logic          s_tlast;
   logic          s_tvalid;
   logic          s_tready;
   logic [1343:0] m_block_o;
   logic [7:0]    m_rate_bytes_o;
   logic          m_last_o;
   logic          m_valid_o;
   logic          m_ready_i;
   logic          busy_o;
`ifdef ABSORB_PROTO_CHECK_EN
   logic          proto_err_o;
`endif

   keccak_absorb_buffer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start_i),
      .mode_i         (mode_i),
      .s_tdata        (s_tdata),
      .s_tkeep        (s_tkeep),
      .s_tlast        (s_tlast),
      .s_tvalid       (s_tvalid),
      .s_tready       (s_tready),
      .m_block_o      (m_block_o),
      .m_rate_bytes_o (m_rate_bytes_o),
      .m_last_o       (m_last_o),
      .m_valid_o      (m_valid_o),
      .m_ready_i      (m_ready_i),
      .busy_o         (busy_o)
`ifdef ABSORB_PROTO_CHECK_EN
      ,
      .proto_err_o    (proto_err_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1343:0] blk;
      logic          last;
      logic [7:0]    rate;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         tests = 0;
   int         fails = 0;
   logic [7:0] msg [0:511];
   logic [7:0] pad [0:511];

   function automatic int tb_rate(input logic [1:0] m);
      case (m)
         2'd0:    return 136;
         2'd1:    return 72;
         2'd2:    return 168;
         default: return 136;
      endcase
   endfunction

   function automatic logic [7:0] tb_dom(input logic [1:0] m);
      return (m >= 2'd2) ? 8'h1F : 8'h06;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic check_blk(input string name, input logic [1343:0] act, input logic [1343:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         for (int j = 0; j < 168; j++) begin
            if (act[8*j +: 8] !== req[8*j +: 8]) begin
               $display("FAIL %s byte %0d: got %02h want %02h", name, j, act[8*j +: 8], req[8*j +: 8]);
               break;
            end
         end
      end
   endtask

   // Monitor: every accepted output block is compared with the next queued expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && m_valid_o === 1'b1 && m_ready_i === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_block: got a block, want none");
         end else begin
            mon_e = exp_q.pop_front();
            check_blk("block", m_block_o, mon_e.blk);
            check("last", 64'(m_last_o), 64'(mon_e.last));
            check("rate", 64'(m_rate_bytes_o), 64'(mon_e.rate));
         end
      end
   end

   task automatic build_expected(input logic [1:0] m, input int len, input int seed);
      int   rate;
      int   total;
      exp_t e;
      rate  = tb_rate(m);
      total = (len / rate + 1) * rate;
      for (int i = 0; i < 512; i++) begin
         msg[i] = 8'((i * 13) + seed + 1);
         pad[i] = (i < len) ? msg[i] : 8'h00;
      end
      pad[len]       = pad[len] ^ tb_dom(m);
      pad[total - 1] = pad[total - 1] ^ 8'h80;
      for (int k = 0; k < total / rate; k++) begin
         e.blk  = '0;
         for (int j = 0; j < rate; j++) begin
            e.blk[8*j +: 8] = pad[k * rate + j];
         end
         e.last = (k == total / rate - 1);
         e.rate = 8'(rate);
         exp_q.push_back(e);
      end
   endtask

   task automatic start_msg(input logic [1:0] m);
      start_i = 1'b1;
      mode_i  = m;
      @(posedge clk);
      #1;
      start_i = 1'b0;
   endtask

   task automatic send_msg(input int len, input int rate);
      int nb;
      int n;
      int cnt;
      bit fills;
      nb = (len == 0) ? 1 : (len + 31) / 32;
      for (int b = 0; b < nb; b++) begin
         n = (b == nb - 1) ? len - 32 * b : 32;
         for (int k = 0; k < 32; k++) begin
            s_tdata[8*k +: 8] = (k < n) ? msg[32 * b + k] : 8'hA5;
         end
         s_tkeep  = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
         s_tlast  = (b == nb - 1);
         s_tvalid = 1'b1;
         cnt = 0;
         forever begin
            @(negedge clk);
            if (s_tready) begin
               @(posedge clk);
               #1;
               break;
            end
            cnt++;
            if (cnt > 300) break;
         end
         if (cnt > 300) begin
            check("beat_accept_timeout", 64'd0, 64'd1);
            s_tvalid = 1'b0;
            return;
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      fills = ((len % rate) < n);
      @(negedge clk);
      check("latency_t1", 64'(m_valid_o), 64'(fills));
      if (!fills) begin
         @(negedge clk);
         check("latency_t2", 64'(m_valid_o), 64'd1);
      end
   endtask

   task automatic wait_done();
      int cnt;
      cnt = 0;
      while ((exp_q.size() != 0 || busy_o) && cnt < 1000) begin
         @(negedge clk);
         cnt++;
      end
      check("drain", 64'(exp_q.size() == 0 && !busy_o), 64'd1);
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic run_msg(input logic [1:0] m, input int len, input int seed);
      build_expected(m, len, seed);
      start_msg(m);
      send_msg(len, tb_rate(m));
      wait_done();
   endtask

   task automatic stall_proc();
      int cnt;
      cnt = 0;
      while (!m_valid_o && cnt < 300) begin
         @(negedge clk);
         cnt++;
      end
      if (cnt >= 300 || exp_q.size() == 0) begin
         check("stall_wait_valid", 64'd0, 64'd1);
      end else begin
         for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            start_i = (i == 2);
            mode_i  = 2'd2;
            @(negedge clk);
            check_blk("stall_block", m_block_o, exp_q[0].blk);
            check("stall_tready", 64'(s_tready), 64'd0);
            check("stall_valid", 64'(m_valid_o), 64'd1);
         end
      end
      @(posedge clk);
      #1;
      start_i   = 1'b0;
      m_ready_i = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      start_i   = 1'b0;
      mode_i    = 2'd0;
      s_tdata   = '0;
      s_tkeep   = '0;
      s_tlast   = 1'b0;
      s_tvalid  = 1'b0;
      m_ready_i = 1'b1;
      #22;
      check("rst_tready", 64'(s_tready), 64'd0);
      check("rst_valid", 64'(m_valid_o), 64'd0);
      check("rst_last", 64'(m_last_o), 64'd0);
      check("rst_rate", 64'(m_rate_bytes_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check_blk("rst_block", m_block_o, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_msg(2'd0, 0, 3);
      run_msg(2'd2, 168, 17);
      run_msg(2'd1, 96, 41);
      run_msg(2'd0, 135, 77);
      run_msg(2'd1, 150, 5);

      m_ready_i = 1'b0;
      build_expected(2'd0, 200, 9);
      start_msg(2'd0);
      fork
         send_msg(200, 136);
         stall_proc();
      join
      wait_done();

      start_msg(2'd2);
      s_tdata  = {8{32'hDEAD_BEEF}};
      s_tkeep  = 32'hFFFF_FFFF;
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n    = 1'b0;
      s_tvalid = 1'b0;
      #1;
      check("abort_tready", 64'(s_tready), 64'd0);
      check("abort_valid", 64'(m_valid_o), 64'd0);
      check("abort_last", 64'(m_last_o), 64'd0);
      check("abort_rate", 64'(m_rate_bytes_o), 64'd0);
      check("abort_busy", 64'(busy_o), 64'd0);
      check_blk("abort_block", m_block_o, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_msg(2'd3, 100, 23);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/keccak_absorb_buffer.md
Name: keccak_absorb_buffer

Overview:
- Input stage directly upstream of the Keccak permutation core.
- Accepts a 256-bit byte-keyed message stream, packs bytes into rate-sized blocks for the selected mode, and carries beat overflow across block boundaries.
- Applies the domain suffix and pad10*1 padding, then hands complete rate blocks to the permutation over a valid/ready interface.

Parameters:
- DWIDTH, 256: input data width in bits.
- KEEP_WIDTH, 32: input byte-enable width (DWIDTH/8).
- RATE_MAX_BITS, 1344: output block width (largest rate, SHAKE128).
- CARRY_WIDTH, 192: carry register width in bits (24 bytes).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse starting a new message; honoured only in IDLE
- mode_i  in  2  keccak_mode, sampled on start_i
- s_tdata  in  256  message bytes, byte k at bits [8k+7:8k]
- s_tkeep  in  32  byte enables, contiguous from bit 0
- s_tlast  in  1  final beat of message
- s_tvalid  in  1  beat valid
- s_tready  out  1  beat accepted when s_tvalid and s_tready are both high
- m_block_o  out  1344  rate block, byte j at bits [8j+7:8j]; bytes at or above the rate are zero
- m_rate_bytes_o  out  8  rate in bytes for the latched mode
- m_last_o  out  1  block is the final, padded block
- m_valid_o  out  1  block valid
- m_ready_i  in  1  permutation accepts block
- busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE, s_tready=0, m_valid_o=0, m_last_o=0, m_block_o=0, m_rate_bytes_o=0, busy_o=0, fill=0, carry=0, last_seen=0.
- Rates in bytes: SHA3_256=136, SHA3_512=72, SHAKE128=168, SHAKE256=136.
- Domain byte: 0x06 for SHA3_*, 0x1F for SHAKE*.
- IDLE:
  - start_i latches the mode and clears block, fill, carry and last_seen; next state ABSORB.
  - start_i is ignored in every other state.
- ABSORB:
  - s_tready=1. An accepted beat of n bytes (n = popcount of s_tkeep) writes into block bytes fill..min(fill+n, rate)-1.
  - Bytes past the rate go to carry, capped at 24 bytes.
  - If fill+n >= rate: go to EMIT, m_last_o=0, last_seen=s_tlast.
  - Else if s_tlast: fill+=n, go to PAD.
  - Else: fill+=n, stay in ABSORB.
  - n=0 with s_tlast is legal (empty tail) and goes to PAD.
- PAD (1 cycle):
  - block[fill] ^= domain byte; block[rate-1] ^= 0x80.
  - When fill=rate-1 these combine to 0x86 (SHA3) or 0x9F (SHAKE).
  - Next state EMIT with m_last_o=1.
- EMIT:
  - m_valid_o=1; block and m_last_o hold stable until m_ready_i.
  - On handshake, if m_last_o=1: go to IDLE.
  - On handshake otherwise: block is cleared, carry (c bytes) moves to bytes 0..c-1, fill=c. Next state is PAD if last_seen, else ABSORB.
  - A message ending exactly on a rate boundary therefore emits an extra block of pure padding.
- Latency:
  - A filling beat accepted in cycle t gives m_valid_o in cycle t+1.
  - A final beat that leaves fill < rate gives m_valid_o in cycle t+2.
- Input rules: every non-last beat must have s_tkeep all ones. Under this rule fill stays a multiple of 8 and the carry never exceeds 24 bytes.
- s_tready is 0 in IDLE, PAD and EMIT; no beat is taken while a block is pending.

Optional Feature:
- Macro ABSORB_PROTO_CHECK_EN.
- Defined: adds port proto_err_o (out, 1). It is a sticky flag set when an accepted beat has non-contiguous s_tkeep, or a non-last beat has s_tkeep != 32'hFFFFFFFF. Cleared by reset or an honoured start_i. Datapath behaviour is unchanged.
- Undefined: no port and no checker logic; output for illegal input is unspecified.

Decomposition:
- keccak_pkg holds:
  - keccak_mode as a 2-bit enum: SHA3_256=0, SHA3_512=1, SHAKE128=2, SHAKE256=3.
  - Rate-byte constants per mode.
  - SHA3_SUFFIX_BYTE=8'h06 and SHAKE_SUFFIX_BYTE=8'h1F.
  - PAD_FINAL_BYTE=8'h80.
  - absorb_state_e {IDLE, ABSORB, PAD, EMIT}.
  - Existing CARRY_WIDTH and KEEP_WIDTH.
- One sub-module, keccak_pad_gen: combinational; takes block, fill, rate and mode, returns the padded block. Instantiated in the PAD path.

Test Plan:
- SHA3_256, empty message (one beat, keep=0, tlast) -> one block with m_last_o=1, byte0=0x06, byte135=0x80, all other bytes 0, m_rate_bytes_o=136.
- SHAKE128, 5 full beats + last beat of 8 bytes (168 B total) -> block 1 holds the 168 bytes, m_last_o=0; block 2 has byte0=0x1F, byte167=0x80, m_last_o=1.
- SHA3_512, 3 full beats (96 B) with tlast -> block 1 = bytes 0..71; block 2 holds 24 carried bytes at 0..23, byte24=0x06, byte71=0x80.
- SHA3_256, 135-byte message -> byte135=0x86 in a single final block.
- Hold m_ready_i=0 for 10 cycles in EMIT -> m_block_o stable, s_tready=0, no beats lost; a start_i pulse here is ignored.
- Assert rst_n low mid-ABSORB, then restart with SHAKE256 -> outputs at reset values immediately; the new message's blocks show no residue from the aborted one.
